// File: rtl/ladybird_serial_responder.sv
// Host command responder: decodes ping/read/write commands from the UART
// byte stream, issues 32-bit memory requests and streams response bytes back.
module ladybird_serial_responder #(
  parameter logic [7:0] OP_WRITE = 8'h77,
  parameter logic [7:0] OP_READ  = 8'h72,
  parameter logic [7:0] OP_PING  = 8'h70,
  parameter logic [7:0] ACK      = 8'h06,
  parameter logic [7:0] NAK      = 8'h15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_MEM_REQ, S_MEM_WAIT, S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic        op_we_q, op_we_d;         // latched command: 1 = write
  logic [1:0]  cnt_q, cnt_d;             // field byte index, wraps 3 -> 0
  logic [1:0]  left_q, left_d;           // response bytes remaining after tx_data_q
  logic [23:0] resp_q, resp_d;           // upper read-data bytes not yet presented
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        mem_valid_q, mem_valid_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic rx_fire, tx_fire, mem_fire, is_rw;

  // Only the byte-collecting states take input; forced low while in reset.
  assign rx_ready = !rst && (state_q == S_IDLE || state_q == S_ADDR || state_q == S_WDATA);
  assign rx_fire  = rx_valid && rx_ready;
  assign tx_fire  = tx_valid_q && tx_ready;
  assign mem_fire = mem_valid_q && mem_ready;
  assign is_rw    = (rx_data == OP_WRITE) || (rx_data == OP_READ);

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign mem_valid = mem_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (rx_fire) state_d = is_rw ? S_ADDR : S_RESP;
      S_ADDR:     if (rx_fire && cnt_q == 2'd3) state_d = op_we_q ? S_WDATA : S_MEM_REQ;
      S_WDATA:    if (rx_fire && cnt_q == 2'd3) state_d = S_MEM_REQ;
      S_MEM_REQ:  if (mem_fire) state_d = op_we_q ? S_RESP : S_MEM_WAIT;
      S_MEM_WAIT: if (mem_rvalid) state_d = S_RESP;
      S_RESP:     if (tx_fire && left_q == 2'd0) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values; every bus output is registered from these
  always_comb begin
    op_we_d     = op_we_q;
    cnt_d       = cnt_q;
    left_d      = left_q;
    resp_d      = resp_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    case (state_q)
      S_IDLE: if (rx_fire) begin
        op_we_d = (rx_data == OP_WRITE);
        cnt_d   = 2'd0;
        if (!is_rw) begin
          tx_valid_d = 1'b1;
          tx_data_d  = (rx_data == OP_PING) ? ACK : NAK;
          left_d     = 2'd0;
        end
      end
      S_ADDR: if (rx_fire) begin
        // Little-endian: shifting in from the top leaves byte 0 in [7:0]
        addr_d = {rx_data, addr_q[31:8]};
        cnt_d  = cnt_q + 2'd1;
        if (cnt_q == 2'd3 && !op_we_q) begin
          mem_valid_d = 1'b1;
          mem_we_d    = 1'b0;
        end
      end
      S_WDATA: if (rx_fire) begin
        wdata_d = {rx_data, wdata_q[31:8]};
        cnt_d   = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          mem_valid_d = 1'b1;
          mem_we_d    = 1'b1;
        end
      end
      S_MEM_REQ: if (mem_fire) begin
        mem_valid_d = 1'b0;
        if (op_we_q) begin
          tx_valid_d = 1'b1;
          tx_data_d  = ACK;
          left_d     = 2'd0;
        end
      end
      S_MEM_WAIT: if (mem_rvalid) begin
        tx_valid_d = 1'b1;
        tx_data_d  = mem_rdata[7:0];
        resp_d     = mem_rdata[31:8];
        left_d     = 2'd3;
      end
      S_RESP: if (tx_fire) begin
        if (left_q == 2'd0) begin
          tx_valid_d = 1'b0;
        end else begin
          tx_data_d = resp_q[7:0];
          resp_d    = {8'h00, resp_q[23:8]};
          left_d    = left_q - 2'd1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset abandons any partial command or response
  always_ff @(posedge clk) begin
    if (rst) begin
      op_we_q     <= 1'b0;
      cnt_q       <= 2'd0;
      left_q      <= 2'd0;
      resp_q      <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      op_we_q     <= op_we_d;
      cnt_q       <= cnt_d;
      left_q      <= left_d;
      resp_q      <= resp_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

endmodule

// File: tb/tb_ladybird_serial_responder.sv
// Directed bench for ladybird_serial_responder: ping, write, read,
// back-pressure, bad opcode, mid-command reset and back-to-back commands.
module tb_ladybird_serial_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;

  int checks = 0;
  int errors = 0;

  ladybird_serial_responder dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // Inputs change and outputs are observed on the falling edge.
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    rx_data = b; rx_valid = 1'b1;
    while (!rx_ready && t < 50) begin @(negedge clk); t++; end
    if (!rx_ready) begin
      checks++; errors++;
      $display("FAIL send_byte_timeout byte %h rx_ready %b required 1", b, rx_ready);
    end
    @(negedge clk);
    rx_valid = 1'b0; rx_data = 8'h00;
  endtask

  // Drains n tx bytes (random tx_ready if rnd), reporting stability and rx_ready observations.
  task automatic collect_tx(input int n, input bit rnd, output logic [31:0] got,
                            output int nbytes, output bit stable_ok, output bit rxr_ok);
    logic [7:0] held;
    bit prev_stall, r;
    got = '0; nbytes = 0; stable_ok = 1'b1; rxr_ok = 1'b1; prev_stall = 1'b0; held = '0;
    for (int cyc = 0; cyc < 300 && nbytes < n; cyc++) begin
      if (tx_valid) begin
        if (rx_ready) rxr_ok = 1'b0;
        if (prev_stall && tx_data !== held) stable_ok = 1'b0;
        r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        tx_ready = r;
        if (r) begin
          got[8*nbytes +: 8] = tx_data;
          nbytes++;
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          held = tx_data;
        end
      end else begin
        tx_ready = 1'b0;
        prev_stall = 1'b0;
      end
      @(negedge clk);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; rx_valid = 0; rx_data = 0; tx_ready = 0;
    mem_ready = 0; mem_rdata = 0; mem_rvalid = 0;
    repeat (2) @(negedge clk);
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready got %b exp 0", rx_ready); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b exp 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h exp 00", tx_data); end
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got %b exp 0", mem_valid); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got %h exp 0", mem_wdata); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_idle_rx_ready got %b exp 1", rx_ready); end
  endtask

  task automatic test_ping;
    logic [31:0] got; int nb; bit st, rr;
    send_byte(8'h70);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h06) begin errors++; $display("FAIL ping_latency got v=%b d=%h exp v=1 d=06", tx_valid, tx_data); end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL ping_rx_ready got %b exp 0", rx_ready); end
    collect_tx(1, 1'b0, got, nb, st, rr);
    checks++; if (nb !== 1 || got[7:0] !== 8'h06) begin errors++; $display("FAIL ping_byte got n=%0d d=%h exp n=1 d=06", nb, got[7:0]); end
    checks++; if (tx_valid !== 1'b0 || rx_ready !== 1'b1 || mem_valid !== 1'b0) begin
      errors++; $display("FAIL ping_done got txv=%b rxr=%b memv=%b exp 0 1 0", tx_valid, rx_ready, mem_valid); end
  endtask

  task automatic test_write;
    logic [31:0] got; int nb; bit st, rr;
    send_byte(8'h77);
    send_byte(8'h10); send_byte(8'h00); send_byte(8'h00); send_byte(8'h80);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem_valid !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h8000_0010 || mem_wdata !== 32'hDEAD_BEEF) begin
        errors++; $display("FAIL write_req_hold%0d got v=%b we=%b a=%h d=%h exp 1 1 80000010 deadbeef",
                           i, mem_valid, mem_we, mem_addr, mem_wdata);
      end
      @(negedge clk);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL write_valid_drop got %b exp 0", mem_valid); end
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h06) begin errors++; $display("FAIL write_ack_latency got v=%b d=%h exp 1 06", tx_valid, tx_data); end
    collect_tx(1, 1'b0, got, nb, st, rr);
    checks++; if (nb !== 1 || got[7:0] !== 8'h06) begin errors++; $display("FAIL write_ack got n=%0d d=%h exp 1 06", nb, got[7:0]); end
    checks++; if (tx_valid !== 1'b0 || mem_valid !== 1'b0) begin errors++; $display("FAIL write_done got txv=%b memv=%b exp 0 0", tx_valid, mem_valid); end
  endtask

  task automatic test_read;
    logic [31:0] got; int nb; bit st, rr;
    send_byte(8'h72);
    send_byte(8'h04); send_byte(8'h00); send_byte(8'h00); send_byte(8'h80);
    checks++; if (mem_valid !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h8000_0004) begin
      errors++; $display("FAIL read_req got v=%b we=%b a=%h exp 1 0 80000004", mem_valid, mem_we, mem_addr); end
    // rvalid coinciding with acceptance must be ignored
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_AAAA;
    @(negedge clk);
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    checks++; if (mem_valid !== 1'b0 || tx_valid !== 1'b0) begin errors++; $display("FAIL read_wait got memv=%b txv=%b exp 0 0", mem_valid, tx_valid); end
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h78) begin errors++; $display("FAIL read_first_byte got v=%b d=%h exp 1 78", tx_valid, tx_data); end
    collect_tx(4, 1'b0, got, nb, st, rr);
    checks++; if (nb !== 4 || got !== 32'h1234_5678) begin errors++; $display("FAIL read_bytes got n=%0d d=%h exp 4 12345678", nb, got); end
    checks++; if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin errors++; $display("FAIL read_done got txv=%b rxr=%b exp 0 1", tx_valid, rx_ready); end
  endtask

  task automatic test_back_pressure;
    logic [31:0] got; int nb; bit st, rr;
    send_byte(8'h72);
    send_byte(8'h20); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    checks++; if (mem_addr !== 32'h0000_0020) begin errors++; $display("FAIL bp_addr got %h exp 00000020", mem_addr); end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    collect_tx(4, 1'b1, got, nb, st, rr);
    checks++; if (nb !== 4 || got !== 32'hCAFE_F00D) begin errors++; $display("FAIL bp_bytes got n=%0d d=%h exp 4 cafef00d", nb, got); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL bp_stable got %b exp 1", st); end
    checks++; if (rr !== 1'b1) begin errors++; $display("FAIL bp_rx_ready_low got %b exp 1", rr); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL bp_done got txv=%b exp 0", tx_valid); end
  endtask

  task automatic test_bad_opcode;
    logic [31:0] got; int nb; bit st, rr;
    send_byte(8'h41);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h15) begin errors++; $display("FAIL nak_latency got v=%b d=%h exp 1 15", tx_valid, tx_data); end
    collect_tx(1, 1'b0, got, nb, st, rr);
    checks++; if (nb !== 1 || got[7:0] !== 8'h15) begin errors++; $display("FAIL nak_byte got n=%0d d=%h exp 1 15", nb, got[7:0]); end
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0 || mem_valid !== 1'b0 || rx_ready !== 1'b1) begin
      errors++; $display("FAIL stray_rvalid got txv=%b memv=%b rxr=%b exp 0 0 1", tx_valid, mem_valid, rx_ready); end
    send_byte(8'h70);
    collect_tx(1, 1'b0, got, nb, st, rr);
    checks++; if (nb !== 1 || got[7:0] !== 8'h06) begin errors++; $display("FAIL stray_ping got n=%0d d=%h exp 1 06", nb, got[7:0]); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] got; int nb; bit st, rr; bit saw_mem;
    send_byte(8'h77); send_byte(8'h10); send_byte(8'h00);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (rx_ready !== 1'b0 || tx_valid !== 1'b0 || tx_data !== 8'h00 || mem_valid !== 1'b0 ||
                  mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++; $display("FAIL midrst_outputs got rxr=%b txv=%b txd=%h mv=%b we=%b a=%h d=%h exp all 0",
                         rx_ready, tx_valid, tx_data, mem_valid, mem_we, mem_addr, mem_wdata); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL midrst_idle got rxr=%b exp 1", rx_ready); end
    send_byte(8'h70);
    saw_mem = mem_valid;
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h06) begin errors++; $display("FAIL midrst_ping got v=%b d=%h exp 1 06", tx_valid, tx_data); end
    collect_tx(1, 1'b0, got, nb, st, rr);
    checks++; if (nb !== 1 || got[7:0] !== 8'h06 || saw_mem !== 1'b0 || mem_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_resp got n=%0d d=%h memv=%b/%b exp 1 06 0/0", nb, got[7:0], saw_mem, mem_valid); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] got; int nb; bit st, rr;
    send_byte(8'h70);
    collect_tx(1, 1'b0, got, nb, st, rr);
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", rx_ready); end
    send_byte(8'h99);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h15) begin errors++; $display("FAIL b2b_second got v=%b d=%h exp 1 15", tx_valid, tx_data); end
    collect_tx(1, 1'b0, got, nb, st, rr);
    checks++; if (nb !== 1 || got[7:0] !== 8'h15 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_done got n=%0d d=%h txv=%b exp 1 15 0", nb, got[7:0], tx_valid); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_ping;
    test_write;
    test_read;
    test_back_pressure;
    test_bad_opcode;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ladybird_serial_responder.md
Name: ladybird_serial_responder

Overview:
- Host-side command responder on the UART byte stream of ladybird_serial_interface.
- Consumes received bytes (serial interface o_data/o_valid/o_ready), decodes host read/write/ping commands, and issues 32-bit memory-bus requests.
- Returns response bytes into the serial interface transmit path (i_data/i_valid/i_ready).
- Replaces the loopback path in the top level, so the host can peek and poke the core's memory.

Parameters:
- OP_WRITE, 8'h77, opcode byte for a write ('w').
- OP_READ, 8'h72, opcode byte for a read ('r').
- OP_PING, 8'h70, opcode byte for a ping ('p').
- ACK, 8'h06, response byte for a completed write or ping.
- NAK, 8'h15, response byte for an unknown opcode.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  received byte from the serial interface
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  responder accepts rx_data
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  serial interface accepts tx_data
- mem_valid  out  1  memory request valid
- mem_ready  in  1  memory accepts request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  32  request address
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data
- mem_rvalid  in  1  read data valid (one-cycle pulse)

Behaviour:
- Clocking/reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values (while rst=1): state=IDLE; rx_ready=0; tx_valid=0; tx_data=0; mem_valid=0; mem_we=0; mem_addr=0; mem_wdata=0; byte counter=0.
- Reset mid-operation: abandon any partial command, pending request or response. Return to IDLE the cycle after rst deasserts. Do not replay anything.
- Handshakes:
  - A transfer occurs on a cycle where valid and ready are both 1.
  - tx_valid, tx_data, mem_valid, mem_we, mem_addr and mem_wdata are registered. Once valid is asserted, they hold stable until the handshake completes.
- rx_ready is 1 only in IDLE, ADDR and WDATA; 0 otherwise.
- Multi-byte fields are little-endian: first byte goes to bits [7:0].
- A 2-bit byte counter indexes the field bytes and wraps 3 -> 0 on field completion.
- States:
  - IDLE: on an rx handshake, decode the opcode.
    - OP_WRITE or OP_READ -> ADDR, latch op.
    - OP_PING -> RESP with tx_data=ACK, 1 byte.
    - Any other value -> RESP with tx_data=NAK, 1 byte.
  - ADDR: shift 4 bytes into mem_addr. On the 4th byte: write -> WDATA; read -> MEM_REQ.
  - WDATA: shift 4 bytes into mem_wdata. On the 4th byte -> MEM_REQ.
  - MEM_REQ: mem_valid=1, mem_we=op. On mem_ready: write -> RESP (ACK, 1 byte); read -> MEM_WAIT. mem_valid drops the cycle after acceptance.
  - MEM_WAIT: on mem_rvalid, capture mem_rdata -> RESP, 4 bytes, starting with bits [7:0].
  - RESP: tx_valid=1. On each tx handshake, present the next byte. After the last byte, tx_valid=0 and state returns to IDLE.
- Latency:
  - Opcode or field byte accepted at edge N -> next state visible at N+1.
  - Ping or NAK: tx_valid=1 at N+1.
  - Final field byte at N -> mem_valid=1 at N+1.
  - mem_ready at M -> write ACK tx_valid at M+1.
  - mem_rvalid at R -> first read byte at R+1.
- mem_rvalid outside MEM_WAIT is ignored.
- mem_rvalid in the same cycle as read acceptance is not captured. Responses must arrive at least one cycle after acceptance.
- rx bytes arriving while rx_ready=0 are left to back-pressure: the serial interface holds them. The responder never drops bytes.
- tx_ready held low indefinitely: remain in RESP; no timeout.
- Back-to-back commands: the next opcode can be accepted the cycle after the last tx handshake (IDLE).

Test Plan:
- Ping: send 70 -> exactly one tx byte 06, then rx_ready=1 again; no mem_valid.
- Write: send 77 10 00 00 80 EF BE AD DE -> one mem request, mem_we=1, mem_addr=8000_0010, mem_wdata=DEAD_BEEF; with mem_ready delayed 3 cycles, mem_valid is held with stable fields; then tx 06.
- Read: send 72 04 00 00 80; memory returns 1234_5678 two cycles after acceptance -> mem_we=0, mem_addr=8000_0004; tx bytes 78 56 34 12 in order.
- Back-pressure: during the read response, toggle tx_ready randomly -> bytes are not duplicated or skipped; tx_data is stable while tx_valid=1 and tx_ready=0; rx_ready=0 throughout RESP.
- Bad opcode and stray input: send 41 -> tx 15; a stray mem_rvalid pulse in IDLE has no effect; the next ping still returns 06.
- Reset mid-command: send 77 10 00, assert rst for one cycle, then send 70 -> no mem request issued; tx 06 only; all outputs read their reset values during rst.
